// File: rtl/sdram_ch_arbiter.sv
// Round-robin arbiter sharing one edge-triggered SDRAM channel among four
// level-handshake requesters; SDRAM_ARB_REFRESH_EN adds the refresh keeper.
module sdram_ch_arbiter #(
  parameter int REFRESH_INTERVAL = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [99:0] req_addr,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_wr,
  input  logic [31:0] req_din,
  output logic [3:0]  req_ack,
  output logic [7:0]  req_dout,
  output logic [24:0] ch_addr,
  output logic        ch_rd,
  output logic        ch_wr,
  output logic [7:0]  ch_din,
  input  logic [7:0]  ch_dout,
  input  logic        ch_busy,
  output logic        ref_active
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        we_q, we_d;
  logic        is_ref_q, is_ref_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  dout_q, dout_d;

  logic        ref_pend;
  logic [24:0] ref_addr;
  logic        gnt_fire;

  logic [3:0]  req_any;
  logic        sel_vld;
  logic [1:0]  sel;
  logic [1:0]  idx;

  assign req_any = req_rd | req_wr;

  // Descending scan so the lowest offset from rr_q wins.
  always_comb begin
    sel_vld = 1'b0;
    sel     = rr_q;
    idx     = rr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_q + 2'(k);
      if (req_any[idx]) begin
        sel_vld = 1'b1;
        sel     = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    is_ref_d = is_ref_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ack_d    = '0;
    dout_d   = dout_q;
    gnt_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!ch_busy && (ref_pend || sel_vld)) begin
          gnt_fire = 1'b1;
          state_d  = ISSUE;
          if (ref_pend) begin
            is_ref_d = 1'b1;
            we_d     = 1'b0;
            addr_d   = ref_addr;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
          end else begin
            is_ref_d = 1'b0;
            gnt_d    = sel;
            we_d     = req_wr[sel];
            addr_d   = req_addr[25*sel +: 25];
            din_d    = req_din[8*sel +: 8];
            rd_d     = ~req_wr[sel];
            wr_d     = req_wr[sel];
          end
        end
      end
      ISSUE: begin
        if (ch_busy) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Ack is raised on entry to DONE so it is visible during DONE.
        if (!ch_busy) begin
          state_d = DONE;
          if (!is_ref_q) begin
            dout_d       = ch_dout;
            ack_d[gnt_q] = 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        is_ref_d = 1'b0;
        if (!is_ref_q) begin
          rr_d = gnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      is_ref_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack_q    <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      is_ref_q <= is_ref_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
    end
  end

`ifdef SDRAM_ARB_REFRESH_EN
  localparam int CW = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] CntMax = CW'(REFRESH_INTERVAL);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   shadow_q, shadow_d;
  logic          hit;

  // shadow mirrors the controller's last-word tracker.
  always_comb begin
    hit      = gnt_fire && !we_d && (addr_d[24:1] == shadow_q);
    shadow_d = shadow_q;
    if (gnt_fire) begin
      shadow_d = we_d ? '1 : addr_d[24:1];
    end
    if (hit) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '1;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign ref_pend   = (cnt_q == CntMax);
  assign ref_addr   = {shadow_q, 1'b0};
  assign ref_active = is_ref_q;
`else
  assign ref_pend   = 1'b0;
  assign ref_addr   = '0;
  assign ref_active = 1'b0;
`endif

  assign req_ack  = ack_q;
  assign req_dout = dout_q;
  assign ch_addr  = addr_q;
  assign ch_rd    = rd_q;
  assign ch_wr    = wr_q;
  assign ch_din   = din_q;

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Randomized and directed bench for sdram_ch_arbiter with a channel model
// and a round-robin / memory reference model.
module tb_sdram_ch_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [99:0] req_addr;
  logic [3:0]  req_rd;
  logic [3:0]  req_wr;
  logic [31:0] req_din;
  logic [3:0]  req_ack;
  logic [7:0]  req_dout;
  logic [24:0] ch_addr;
  logic        ch_rd;
  logic        ch_wr;
  logic [7:0]  ch_din;
  logic [7:0]  ch_dout;
  logic        ch_busy;
  logic        ref_active;

  always #5 clk = ~clk;

  sdram_ch_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_din    (req_din),
    .req_ack    (req_ack),
    .req_dout   (req_dout),
    .ch_addr    (ch_addr),
    .ch_rd      (ch_rd),
    .ch_wr      (ch_wr),
    .ch_din     (ch_din),
    .ch_dout    (ch_dout),
    .ch_busy    (ch_busy),
    .ref_active (ref_active)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_init(logic [24:0] a);
    logic [15:0] w;
    w = {a[8:1] ^ 8'hC3, a[8:1] + 8'h11};
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  // channel model
  int          busy_cnt = 0;
  int          viol = 0;
  logic        prv_rd = 1'b0;
  logic        prv_wr = 1'b0;
  logic [7:0]  nxt_dout = '0;
  logic [7:0]  chan_mem [int];
  logic        rise;
  logic [24:0] ev_addr;
  logic        ev_wr;
  logic [7:0]  ev_din;
  logic        ev_ref;

  // reference model
  logic [3:0]  seen;
  int          mp;
  logic        outst;
  int          pg;
  logic [24:0] pa;
  logic        pw;
  logic [7:0]  pd;
  logic [23:0] m_shadow;
  logic [7:0]  last_dout;
  logic [7:0]  exp_mem [int];
  int          order_q[$];
  int          cyc = 0;
  int          rst_cyc = 0;
  int          wait_cnt = 0;
  int          n_rise = 0;
  int          n_dummy = 0;
  int          dummy_cyc = 0;
  int          dummy_gap = 0;
  logic [24:0] dummy_addr;

  task automatic chan_step();
    rise = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        ch_busy = 1'b0;
        ch_dout = nxt_dout;
      end
    end
    if ((ch_rd && !prv_rd) || (ch_wr && !prv_wr)) begin
      if (ch_busy) begin
        viol++;
      end else begin
        rise     = 1'b1;
        ev_addr  = ch_addr;
        ev_wr    = ch_wr;
        ev_din   = ch_din;
        ev_ref   = ref_active;
        ch_busy  = 1'b1;
        busy_cnt = 6;
        if (ch_wr) begin
          chan_mem[int'(ch_addr)] = ch_din;
          nxt_dout = ch_din;
        end else if (chan_mem.exists(int'(ch_addr))) begin
          nxt_dout = chan_mem[int'(ch_addr)];
        end else begin
          nxt_dout = byte_init(ch_addr);
        end
      end
    end
    prv_rd = ch_rd;
    prv_wr = ch_wr;
  endtask

  task automatic mon_step();
    int eg;
    logic [7:0] ed;
    if (rise) begin
      n_rise++;
      if (ev_ref) begin
`ifdef SDRAM_ARB_REFRESH_EN
        chk("dummy_addr", 32'(ev_addr), 32'({m_shadow, 1'b0}));
        chk("dummy_is_rd", 32'(ev_wr), 0);
`else
        chk("ref_tied", 32'(ev_ref), 0);
`endif
        n_dummy++;
        dummy_gap  = cyc - dummy_cyc;
        dummy_cyc  = cyc;
        dummy_addr = ev_addr;
      end else begin
        chk("overlap", 32'(outst), 0);
        chk("req_pending", 32'(seen == 4'h0), 0);
        eg = 0;
        for (int k = 3; k >= 0; k--) begin
          if (seen[(mp + k) % 4]) eg = (mp + k) % 4;
        end
        pg = eg;
        pa = req_addr[25*eg +: 25];
        pw = req_wr[eg];
        pd = req_din[8*eg +: 8];
        chk("ch_addr", 32'(ev_addr), 32'(pa));
        chk("ch_wr", 32'(ev_wr), 32'(pw));
        if (pw) chk("ch_din", 32'(ev_din), 32'(pd));
        m_shadow = pw ? '1 : pa[24:1];
        outst    = 1'b1;
        wait_cnt = 0;
      end
    end
    if (req_ack != 4'h0) begin
      if (!outst) begin
        chk("spurious_ack", 32'(req_ack), 0);
      end else begin
        chk("ack_idx", 32'(req_ack), 32'(4'b0001 << pg));
        if (pw) begin
          ed = pd;
          exp_mem[int'(pa)] = pd;
        end else if (exp_mem.exists(int'(pa))) begin
          ed = exp_mem[int'(pa)];
        end else begin
          ed = byte_init(pa);
        end
        chk("dout", 32'(req_dout), 32'(ed));
        mp    = (pg + 1) % 4;
        outst = 1'b0;
        order_q.push_back(pg);
        req_rd[pg] = 1'b0;
        req_wr[pg] = 1'b0;
      end
      last_dout = req_dout;
    end else if (req_dout !== last_dout) begin
      chk("dout_hold", 32'(req_dout), 32'(last_dout));
    end
    if (outst) begin
      wait_cnt++;
      if (wait_cnt == 50) chk("ack_timeout", 32'(wait_cnt), 0);
    end
  endtask

  task automatic tick();
    seen = req_rd | req_wr;
    @(negedge clk);
    cyc++;
    chan_step();
    mon_step();
  endtask

  task automatic model_reset();
    outst     = 1'b0;
    mp        = 0;
    m_shadow  = '1;
    last_dout = '0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    model_reset();
    repeat (n) tick();
    reset   = 1'b0;
    rst_cyc = cyc;
  endtask

  task automatic raise(int i, logic wr, logic [24:0] a, logic [7:0] d);
    req_addr[25*i +: 25] = a;
    req_din[8*i +: 8]    = d;
    req_wr[i]            = wr;
    req_rd[i]            = ~wr;
  endtask

  task automatic wait_ack(int i, int lim, output int lat);
    lat = 0;
    while ((req_rd[i] | req_wr[i]) && lat < lim) begin
      tick();
      lat++;
    end
    chk("ack_wait", 32'(req_rd[i] | req_wr[i]), 0);
  endtask

  task automatic wait_all(int lim);
    int t;
    t = 0;
    while ((req_rd != 4'h0 || req_wr != 4'h0 || outst) && t < lim) begin
      tick();
      t++;
    end
    chk("drain_wait", 32'(req_rd | req_wr), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_dout", 32'(req_dout), 0);
    chk("rst_rd", 32'(ch_rd), 0);
    chk("rst_wr", 32'(ch_wr), 0);
    chk("rst_addr", 32'(ch_addr), 0);
    chk("rst_din", 32'(ch_din), 0);
    chk("rst_ref", 32'(ref_active), 0);
  endtask

  initial begin
    int lat;
    int t;
    int n0;
    reset    = 1'b1;
    req_addr = '0;
    req_rd   = '0;
    req_wr   = '0;
    req_din  = '0;
    ch_dout  = '0;
    ch_busy  = 1'b0;
    seen     = '0;
    model_reset();

    do_reset(3);
    chk_reset_vals();

    // idle after reset: refresh keeper behaviour
`ifdef SDRAM_ARB_REFRESH_EN
    t = 0;
    while (n_dummy == 0 && t < 700) begin
      tick();
      t++;
    end
    chk("dummy_seen", 32'(n_dummy), 1);
    chk("dummy_time_ok", 32'((dummy_cyc - rst_cyc) >= 598 &&
                             (dummy_cyc - rst_cyc) <= 604), 1);
    chk("dummy_first_addr", 32'(dummy_addr), 32'(25'h1FFFFFE));
    t = 0;
    while (n_dummy == 1 && t < 700) begin
      tick();
      t++;
    end
    chk("dummy_again", 32'(n_dummy), 2);
    chk("dummy_gap_ok", 32'(dummy_gap >= 598 && dummy_gap <= 604), 1);
`else
    repeat (700) tick();
    chk("quiet_idle", 32'(n_rise), 0);
`endif

    // single read from requester 1
    do_reset(2);
    raise(1, 1'b0, 25'h0000123, 8'h00);
    wait_ack(1, 20, lat);
    chk("lat_le_11", 32'(lat <= 11), 1);
    chk("rd_123", 32'(req_dout), 32'h52);

    // contention from reset: 0 then 2, then 3 before 2
    do_reset(2);
    order_q.delete();
    raise(0, 1'b0, 25'h200, 8'h00);
    raise(2, 1'b0, 25'h301, 8'h00);
    wait_all(60);
    chk("rr_cnt_a", 32'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk("rr_a0", 32'(order_q[0]), 0);
      chk("rr_a1", 32'(order_q[1]), 2);
    end
    order_q.delete();
    raise(2, 1'b0, 25'h302, 8'h00);
    raise(3, 1'b0, 25'h403, 8'h00);
    wait_all(60);
    chk("rr_cnt_b", 32'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk("rr_b0", 32'(order_q[0]), 3);
      chk("rr_b1", 32'(order_q[1]), 2);
    end

    // write then read back
    raise(3, 1'b1, 25'h10, 8'hA5);
    wait_ack(3, 30, lat);
    chk("wr_echo", 32'(req_dout), 32'hA5);
    raise(1, 1'b0, 25'h10, 8'h00);
    wait_ack(1, 30, lat);
    chk("wr_readback", 32'(req_dout), 32'hA5);
`ifdef SDRAM_ARB_REFRESH_EN
    n0 = n_dummy;
    t  = 0;
    while (n_dummy == n0 && t < 700) begin
      tick();
      t++;
    end
    chk("shadow_dummy_seen", 32'(n_dummy - n0), 1);
    chk("shadow_dummy_addr", 32'(dummy_addr), 32'(25'h10));
`endif

    // reset during DRAIN with the request held high
    do_reset(2);
    raise(0, 1'b0, 25'h77, 8'h00);
    repeat (2) tick();
    chk("in_drain_busy", 32'(ch_busy), 1);
    reset = 1'b1;
    model_reset();
    repeat (2) tick();
    chk("rdrain_rd", 32'(ch_rd), 0);
    chk("rdrain_wr", 32'(ch_wr), 0);
    chk("rdrain_ack", 32'(req_ack), 0);
    reset = 1'b0;
    wait_ack(0, 40, lat);
    chk("rdrain_viol", 32'(viol), 0);

    // randomized traffic
    do_reset(2);
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(req_rd[i] | req_wr[i]) && $urandom_range(3) == 0) begin
          raise(i, $urandom_range(2) == 0, 25'($urandom_range(31)),
                8'($urandom));
        end
      end
      tick();
    end
    wait_all(400);

    // periodic same-word reads keep refresh satisfied
    do_reset(2);
    n0 = n_dummy;
    for (int n = 0; n < 1500; n++) begin
      if (n % 20 == 0 && !req_rd[0]) raise(0, 1'b0, 25'h40, 8'h00);
      tick();
    end
    wait_all(60);
    chk("no_dummy_periodic", 32'(n_dummy - n0), 0);

    chk("viol_total", 32'(viol), 0);
    chk("outst_end", 32'(outst), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_ch_arbiter.md
# sdram_ch_arbiter

Shares one 8-bit SDRAM controller channel (edge-triggered rd/wr, busy/dout return) among four requesters using round-robin arbitration. It converts each requester's level req/ack handshake into the channel's rising-edge protocol. It also runs a refresh keeper: the controller refreshes only when a channel re-reads the same 16-bit word, so the keeper injects same-word dummy reads when natural refresh opportunities stop. The block sits between the NES core memory clients (for example CPU, PPU, DMA, save-RAM) and one sdram channel.

## Interface
- REFRESH_INTERVAL, 600: maximum number of clk cycles without a refresh-triggering read before a dummy read is forced (7.8 µs at 85 MHz, with margin).
- clk  in  1  controller clock, same as the sdram block.
- reset  in  1  synchronous, active-high.
- req_addr  in  4x25  per-requester byte address, packed, requester i at [25*i+:25].
- req_rd  in  4  per-requester read request, level.
- req_wr  in  4  per-requester write request, level; takes precedence over req_rd for the same requester.
- req_din  in  4x8  per-requester write data, packed.
- req_ack  out  4  one-cycle completion pulse to the granted requester.
- req_dout  out  8  shared read data, valid in the req_ack cycle, held afterwards.
- ch_addr  out  25  to the channel address input.
- ch_rd  out  1  to the channel rd input.
- ch_wr  out  1  to the channel wr input.
- ch_din  out  8  to the channel din input.
- ch_dout  in  8  from the channel dout output.
- ch_busy  in  1  from the channel busy output.
- ref_active  out  1  high while a dummy refresh read is in flight.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - Grants only when ch_busy=0.
  - Source priority: a pending refresh first, then round-robin starting at rr_ptr.
  - On a grant, latches addr, din and a we flag, and records the grant index.
  - Moves to ISSUE.
- **ISSUE**
  - Drives ch_rd=~we and ch_wr=we. Holds the address and data stable.
  - When ch_busy=1, moves to DRAIN.
- **DRAIN**
  - Drives ch_rd=ch_wr=0. This guarantees a falling edge before the next request.
  - When ch_busy=0, moves to DONE.
- **DONE**
  - Registers req_dout<=ch_dout. For writes the channel echoes din, so this capture happens for writes too.
  - Pulses req_ack[grant] for requester grants only.
  - Sets rr_ptr<=grant+1 (mod 4).
  - Returns to IDLE.
- Requester contract:
  - Hold req_rd/req_wr and operands stable until req_ack.
  - A request still high in the cycle after req_ack is treated as a new request.
- Shadow word register (shadow) mirrors the controller's last-word tracker:
  - Reset value is all ones.
  - A write grant sets it to all ones.
  - A read grant sets it to addr[24:1].
- A read grant whose addr[24:1] equals shadow (before the update) is a refresh hit.
- Refresh counter:
  - Increments every cycle and saturates at REFRESH_INTERVAL.
  - Clears to 0 when a refresh hit is granted, whether natural or dummy.
- refresh_pending = (counter == REFRESH_INTERVAL).
- A dummy read targets {shadow, 1'b0}. Its returned data is discarded: req_dout is unchanged and no ack is issued.
- Reset mid-operation: FSM goes to IDLE and ch_rd/ch_wr go to 0. The next grant waits for ch_busy=0, so any in-flight controller cycle completes unobserved.

## Timing
- Reset values:
  - req_ack=0, req_dout=0, ch_rd=0, ch_wr=0, ch_addr=0, ch_din=0, ref_active=0.
  - rr_ptr=0, counter=0, shadow all ones, FSM in IDLE.
- All outputs are registered.
- Latency from a grant cycle to req_ack, with the controller idle and in normal mode: ISSUE 1–2 cycles, DRAIN = controller busy length (6 cycles at CAS 2), DONE 1 cycle. Total ≤ 11 cycles.
- Back-to-back throughput: one access per FSM round trip. There is a minimum of 1 IDLE cycle between accesses.
- Simultaneous events:
  - Refresh pending and requests present: refresh wins, and rr_ptr is unchanged.
  - Requests from all four requesters: served in rr_ptr order, with no starvation.
- Counter wrap: none. It saturates, so a stalled controller cannot lose a pending refresh.

## Configuration
- SDRAM_ARB_REFRESH_EN defined: the refresh keeper, shadow register and ref_active behave as specified.
- SDRAM_ARB_REFRESH_EN undefined:
  - Counter and shadow are not synthesized.
  - refresh_pending is constant 0 and ref_active is tied 0.
  - Only requester traffic reaches the channel.

## Test plan
- Read via req_rd[1], addr 25'h0000123 -> one ch_rd rise with ch_addr=25'h0000123. req_ack=4'b0010 pulses once within 11 cycles, with req_dout = the model's high byte of word 0x91.
- req_rd[0] and req_rd[2] asserted together from reset -> requester 0 is acked first, then requester 2. The next contention between 2 and 3 serves 3 first.
- req_wr[3] with din 8'hA5 and addr 25'h10, then a read of 25'h10 -> ch_wr seen high with ch_din=8'hA5. The following read returns 8'hA5, and shadow ends at 24'h8.
- (REFRESH_EN) No requests for 600 cycles after reset -> ch_rd rises with ch_addr=25'h1FFFFFE, ref_active is high, no req_ack is issued, and the counter is back to 0.
- (REFRESH_EN) req_rd[0] repeatedly reads 25'h40 every 20 cycles -> no dummy read ever appears.
- Reset asserted during DRAIN -> ch_rd=ch_wr=0 and no ack is issued. A request pending at reset release is granted only after ch_busy falls.
